// File: rtl/bsg_muxi_gatestack_pipe.sv
// Per-bit inverting N:1 mux feeding a 2-entry valid/ready-in, valid/yumi-out buffer.
// Define BSG_MUXI_GATESTACK_SEL_CHECK_EN to add the sticky out-of-range-select flag err_o.
module bsg_muxi_gatestack_pipe #(
  parameter int width_p = 16,
  parameter int els_p   = 2,
  localparam int lg_els_lp = (els_p > 2) ? $clog2(els_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [els_p*width_p-1:0]       data_i,
  input  logic [width_p*lg_els_lp-1:0]   sel_i,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  input  logic                           yumi_i
`ifdef BSG_MUXI_GATESTACK_SEL_CHECK_EN
  , output logic                         err_o
`endif
);

  if (els_p < 2) begin : g_els_check
    $fatal(1, "bsg_muxi_gatestack_pipe: els_p must be at least 2");
  end

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  localparam logic [lg_els_lp:0] els_lim_lp = els_p[lg_els_lp:0];

  state_e                              state_r, state_n;
  logic   [els_p-1:0][width_p-1:0]     words;
  logic   [width_p-1:0]                res;
  logic   [width_p-1:0]                oor;
  logic   [width_p-1:0]                head_r, tail_r;
  logic                                enq, deq;

  assign words = data_i;

  // Out-of-range selects read as a 0 bit, so the inverted result is 1.
  for (genvar b = 0; b < width_p; b++) begin : g_bit
    logic [lg_els_lp-1:0] sel;
    assign sel    = sel_i[b*lg_els_lp +: lg_els_lp];
    assign oor[b] = ({1'b0, sel} >= els_lim_lp);
    assign res[b] = oor[b] ? 1'b1 : ~words[sel][b];
  end

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= EMPTY;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      EMPTY:   if (enq) state_n = ONE;
      ONE:     if (enq && !deq) state_n = FULL;
               else if (!enq && deq) state_n = EMPTY;
      FULL:    if (deq) state_n = ONE;
      default: state_n = EMPTY;
    endcase
  end

  always_comb begin
    ready_o = (state_r != FULL);
    v_o     = (state_r != EMPTY);
  end

  // Head is the output register; tail only holds the second word while full.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      unique case (state_r)
        EMPTY: if (enq) head_r <= res;
        ONE: begin
          if (enq && deq) head_r <= res;
          else if (enq)   tail_r <= res;
        end
        FULL:  if (deq) head_r <= tail_r;
        default: ;
      endcase
    end
  end

  assign data_o = head_r;

`ifdef BSG_MUXI_GATESTACK_SEL_CHECK_EN
  logic err_r;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)       err_r <= 1'b0;
    else if (enq && |oor) err_r <= 1'b1;
  end
  assign err_o = err_r;
`endif

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o))
    else $error("bsg_muxi_gatestack_pipe: yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_muxi_gatestack_pipe.sv
// Self-checking bench for bsg_muxi_gatestack_pipe at width_p=4, els_p=3.
module tb_bsg_muxi_gatestack_pipe;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_o;
  logic [11:0] data_i;
  logic [7:0]  sel_i;
  logic        v_o;
  logic [3:0]  data_o;
  logic        yumi_i;
`ifdef BSG_MUXI_GATESTACK_SEL_CHECK_EN
  logic        err_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  bsg_muxi_gatestack_pipe #(.width_p(4), .els_p(3)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .sel_i    (sel_i),
    .v_o      (v_o),
    .data_o   (data_o),
    .yumi_i   (yumi_i)
`ifdef BSG_MUXI_GATESTACK_SEL_CHECK_EN
    , .err_o  (err_o)
`endif
  );

  typedef struct {
    logic [11:0] data;
    logic [7:0]  sel;
    logic [3:0]  exp;
  } vec_t;

  // Reference: each result bit is the inverse of the selected word's bit, 1 if select >= 3.
  function automatic logic [3:0] ref_mux(input logic [11:0] d, input logic [7:0] s);
    logic [3:0] r;
    int dv, sv, k;
    dv = int'(d);
    sv = int'(s);
    for (int b = 0; b < 4; b++) begin
      k = (sv >> (2 * b)) % 4;
      if (k < 3) r[b] = (((dv >> (k * 4 + b)) % 2) == 0);
      else       r[b] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic ref_oor(input logic [7:0] s);
    int sv;
    sv = int'(s);
    for (int b = 0; b < 4; b++)
      if (((sv >> (2 * b)) % 4) == 3) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    v_i = 1'b0;
    yumi_i = 1'b0;
    reset_n_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
  endtask

  vec_t        vecs[8];
  logic [3:0]  q[$];
  logic [3:0]  tmp;
  logic        rv, ry, enq, err_m;
  logic [11:0] rd;
  logic [7:0]  rs;
  int          got;

  initial begin
    vecs[0] = '{12'hC5A, 8'h55, 4'hA};
    vecs[1] = '{12'hC5A, 8'h86, 4'h7};
    vecs[2] = '{12'hC5A, 8'h00, 4'h5};
    vecs[3] = '{12'hC5A, 8'hAA, 4'h3};
    vecs[4] = '{12'h000, 8'hFF, 4'hF};
    vecs[5] = '{12'hFFF, 8'h00, 4'h0};
    vecs[6] = '{12'h0F0, 8'h41, 4'h6};
    vecs[7] = '{12'hFFF, 8'hC0, 4'h8};

    reset_n_i = 1'b1;
    v_i = 1'b0;
    yumi_i = 1'b0;
    data_i = '0;
    sel_i = '0;
    #2 reset_n_i = 1'b0;
    #1;
    check("reset_v_o", int'(v_o), 0);
    check("reset_ready_o", int'(ready_o), 1);
    check("reset_data_o", int'(data_o), 0);
    tick();
    reset_n_i = 1'b1;

    // Table: single enqueue, scramble inputs, check held result, dequeue.
    for (int i = 0; i < 8; i++) begin
      v_i = 1'b1;
      data_i = vecs[i].data;
      sel_i = vecs[i].sel;
      tick();
      v_i = 1'b0;
      data_i = ~vecs[i].data;
      sel_i = ~vecs[i].sel;
      check($sformatf("vec%0d_v_o", i), int'(v_o), 1);
      check($sformatf("vec%0d_data_o", i), int'(data_o), int'(vecs[i].exp));
      check($sformatf("vec%0d_ready_o", i), int'(ready_o), 1);
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      check($sformatf("vec%0d_drained", i), int'(v_o), 0);
    end

    // Backpressure: fill, ignored third word, drain in order.
    do_reset();
    v_i = 1'b1; data_i = 12'h000; sel_i = 8'h00;
    tick();
    data_i = 12'h005;
    tick();
    check("full_ready_o", int'(ready_o), 0);
    check("full_v_o", int'(v_o), 1);
    check("full_head", int'(data_o), 4'hF);
    data_i = 12'hFFF;
    tick();
    v_i = 1'b0;
    check("full_ignore_ready", int'(ready_o), 0);
    check("full_ignore_head", int'(data_o), 4'hF);
    yumi_i = 1'b1;
    tick();
    check("deq_ready_o", int'(ready_o), 1);
    check("deq_second_word", int'(data_o), 4'hA);
    tick();
    yumi_i = 1'b0;
    check("deq_empty_v_o", int'(v_o), 0);

    // Streaming: yumi follows v_o, 8 words back to back.
    do_reset();
    q.delete();
    got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      check($sformatf("stream_v_o_c%0d", cyc), int'(v_o), (cyc >= 1 && cyc <= 8) ? 1 : 0);
      check($sformatf("stream_ready_c%0d", cyc), int'(ready_o), 1);
      if (v_o) begin
        if (q.size() == 0) check("stream_extra_word", 1, 0);
        else begin
          tmp = q.pop_front();
          check($sformatf("stream_data_%0d", got), int'(data_o), int'(tmp));
        end
        got++;
      end
      yumi_i = v_o;
      v_i = (cyc < 8);
      data_i = 12'($urandom);
      sel_i = 8'($urandom);
      if (cyc < 8) q.push_back(ref_mux(data_i, sel_i));
      tick();
    end
    yumi_i = 1'b0;
    v_i = 1'b0;
    check("stream_count", got, 8);

    // Reset asserted between edges while full.
    v_i = 1'b1; data_i = 12'h123; sel_i = 8'h00;
    tick();
    tick();
    v_i = 1'b0;
    check("pre_reset_full", int'(ready_o), 0);
    #3 reset_n_i = 1'b0;
    #1;
    check("midreset_v_o", int'(v_o), 0);
    check("midreset_ready_o", int'(ready_o), 1);
    check("midreset_data_o", int'(data_o), 0);
    tick();
    reset_n_i = 1'b1;
    tick();
    check("post_reset_v_o_1", int'(v_o), 0);
    tick();
    check("post_reset_v_o_2", int'(v_o), 0);

`ifdef BSG_MUXI_GATESTACK_SEL_CHECK_EN
    do_reset();
    check("err_reset", int'(err_o), 0);
    v_i = 1'b1; data_i = 12'h000; sel_i = 8'h03;
    tick();
    v_i = 1'b0;
    check("err_oor_bit0", int'(data_o[0]), 1);
    check("err_set", int'(err_o), 1);
    yumi_i = 1'b1;
    v_i = 1'b1; sel_i = 8'h00;
    tick();
    v_i = 1'b0;
    tick();
    yumi_i = 1'b0;
    check("err_sticky", int'(err_o), 1);
    do_reset();
    check("err_cleared", int'(err_o), 0);
`endif

    // Randomized traffic against a queue model.
    do_reset();
    q.delete();
    err_m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rv = 1'($urandom_range(0, 1));
      rd = 12'($urandom);
      rs = 8'($urandom);
      ry = v_o && ($urandom_range(0, 3) != 0);
      v_i = rv; data_i = rd; sel_i = rs; yumi_i = ry;
      tick();
      enq = rv && (q.size() != 2);
      if (ry && q.size() != 0) tmp = q.pop_front();
      if (enq) begin
        q.push_back(ref_mux(rd, rs));
        if (ref_oor(rs)) err_m = 1'b1;
      end
      check("rand_v_o", int'(v_o), (q.size() != 0) ? 1 : 0);
      check("rand_ready_o", int'(ready_o), (q.size() != 2) ? 1 : 0);
      if (q.size() != 0) check("rand_data_o", int'(data_o), int'(q[0]));
`ifdef BSG_MUXI_GATESTACK_SEL_CHECK_EN
      check("rand_err_o", int'(err_o), int'(err_m));
`endif
    end
    v_i = 1'b0;
    yumi_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
